// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester mux arbiter: FSM states and mux select values.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/two_one_mux_w.sv
// Width-parameterised 2:1 datapath mux; sel=0 passes a, sel=1 passes b.
module two_one_mux_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] op
);

  assign op = sel ? b : a;

endmodule

// File: rtl/two_one_mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux output between two packet requesters,
// with packet locking, a MAX_HOLD beat limit and back-to-back handoff.
module two_one_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         last0,
  input  logic [W-1:0] a,
  input  logic         req1,
  input  logic         last1,
  input  logic [W-1:0] b,
  input  logic         op_ready,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] op,
  output logic         op_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          cur_req, cur_last, beat;

  // ptr names the side that wins when both request at once.
  function automatic state_e pick(input logic r0, input logic r1, input logic p);
    if (r0 && r1) return p ? ST_G1 : ST_G0;
    if (r0)       return ST_G0;
    if (r1)       return ST_G1;
    return ST_IDLE;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cur_req  = 1'b0;
    cur_last = 1'b0;
    beat     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = pick(req0, req1, ptr_q);
      ST_G0, ST_G1: begin
        cur_req  = (state_q == ST_G1) ? req1 : req0;
        cur_last = (state_q == ST_G1) ? last1 : last0;
        beat     = cur_req & op_ready;
        if (!cur_req || (beat && (cur_last || cnt_q == HOLD_LAST))) begin
          // Release hands priority to the other side and re-arbitrates in the same cycle.
          ptr_d   = (state_q == ST_G0);
          cnt_d   = '0;
          state_d = pick(req0, req1, ptr_d);
        end else if (beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_G0:   sel_d = SEL_A;
      ST_G1:   sel_d = SEL_B;
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt0     = (state_q == ST_G0);
  assign gnt1     = (state_q == ST_G1);
  assign sel      = sel_q;
  assign op_valid = (gnt0 & req0) | (gnt1 & req1);

  two_one_mux_w #(.W(W)) u_mux (
    .a  (a),
    .b  (b),
    .sel(sel_q),
    .op (op)
  );

endmodule

// File: tb/tb_two_one_mux_arbiter.sv
// Directed bench for two_one_mux_arbiter: reset, single requester, contention, hold limit,
// backpressure and abandon scenarios with hand-computed expectations.
module tb_two_one_mux_arbiter;

  localparam int W = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, last0, req1, last1, op_ready;
  logic [W-1:0] a, b;
  logic         gnt0, gnt1, sel, op_valid;
  logic [W-1:0] op;

  int vectors = 0;
  int miscompares = 0;

  two_one_mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .last0(last0), .a(a),
    .req1(req1), .last1(last1), .b(b),
    .op_ready(op_ready),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .op(op), .op_valid(op_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; last0 = 0; req1 = 0; last1 = 0; op_ready = 0; a = '0; b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({gnt0, gnt1, sel, op_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_idle got=%b want=0000", {gnt0, gnt1, sel, op_valid});
    end
    req1 = 1; b = 8'hC3; op_ready = 0;
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op_valid} !== 4'b0111) begin
      miscompares++;
      $display("FAIL reset_pre_g1 got=%b want=0111", {gnt0, gnt1, sel, op_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1, sel, op_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async got=%b want=0000", {gnt0, gnt1, sel, op_valid});
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1; a = 8'h5A; op_ready = 1;
    vectors++;
    if (gnt0 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_early_gnt got=%b want=0", gnt0);
    end
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op_valid, op} !== {4'b1001, 8'h5A}) begin
      miscompares++;
      $display("FAIL single_beat1 got=%b %h want=1001 5a", {gnt0, gnt1, sel, op_valid}, op);
    end
    tick();
    last0 = 1;
    vectors++;
    if ({gnt0, op_valid, op} !== {2'b11, 8'h5A}) begin
      miscompares++;
      $display("FAIL single_beat2 got=%b %h want=11 5a", {gnt0, op_valid}, op);
    end
    tick();
    req0 = 0; last0 = 0;
    #1;
    vectors++;
    if (op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_valid got=%b want=0", op_valid);
    end
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_idle got=%b want=0000", {gnt0, gnt1, sel, op_valid});
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0 = 1; req1 = 1; a = 8'h11; b = 8'h22; last0 = 1; op_ready = 1;
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b100, 8'h11}) begin
      miscompares++;
      $display("FAIL contend_g0 got=%b %h want=100 11", {gnt0, gnt1, sel}, op);
    end
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b011, 8'h22}) begin
      miscompares++;
      $display("FAIL contend_g1 got=%b %h want=011 22", {gnt0, gnt1, sel}, op);
    end
    req0 = 0; req1 = 0; last0 = 0;
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b001, 8'h22}) begin
      miscompares++;
      $display("FAIL contend_idle_sel_hold got=%b %h want=001 22", {gnt0, gnt1, sel}, op);
    end
  endtask

  task automatic test_hold_limit();
    do_reset();
    req0 = 1; req1 = 1; a = 8'h33; b = 8'h44; op_ready = 1;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      vectors++;
      if ({gnt0, gnt1} !== 2'b10) begin
        miscompares++;
        $display("FAIL hold_beat%0d got=%b want=10", i, {gnt0, gnt1});
      end
      tick();
    end
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b011, 8'h44}) begin
      miscompares++;
      $display("FAIL hold_handoff got=%b %h want=011 44", {gnt0, gnt1, sel}, op);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0 = 1; a = 8'h77; op_ready = 1;
    tick();
    tick();
    req1 = 1; b = 8'h88; last0 = 1; op_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({gnt0, gnt1, sel, op_valid, op} !== {4'b1001, 8'h77}) begin
        miscompares++;
        $display("FAIL stall%0d got=%b %h want=1001 77", i, {gnt0, gnt1, sel, op_valid}, op);
      end
    end
    op_ready = 1;
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b011, 8'h88}) begin
      miscompares++;
      $display("FAIL stall_release got=%b %h want=011 88", {gnt0, gnt1, sel}, op);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abandon();
    do_reset();
    req1 = 1; b = 8'h55; op_ready = 1;
    tick();
    req0 = 1; a = 8'h66;
    tick();
    vectors++;
    if ({gnt0, gnt1, op_valid} !== 3'b011) begin
      miscompares++;
      $display("FAIL abandon_pre got=%b want=011", {gnt0, gnt1, op_valid});
    end
    req1 = 0;
    #1;
    vectors++;
    if (op_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abandon_valid got=%b want=0", op_valid);
    end
    tick();
    vectors++;
    if ({gnt0, gnt1, sel, op} !== {3'b100, 8'h66}) begin
      miscompares++;
      $display("FAIL abandon_g0 got=%b %h want=100 66", {gnt0, gnt1, sel}, op);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_hold_limit();
    test_backpressure();
    test_abandon();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
